// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared single-port RAM between the data port, instruction fetch and
// the program loader, and routes each 1-cycle read return back to the port that issued it.
module mem_port_arbiter #(
  parameter int ADDR_W       = 9,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              loader_active
);

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {ST_NORMAL, ST_LOADER, ST_RESUME} state_e;
  typedef enum logic [1:0] {TAG_NONE, TAG_D, TAG_F, TAG_L} tag_e;

  state_e            state_q, state_d;
  tag_e              tag_q, tag_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_NORMAL;
      tag_q    <= TAG_NONE;
      starve_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      tag_q    <= tag_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  // Grant selection and session state; at most one grant per cycle.
  always_comb begin
    d_gnt   = 1'b0;
    f_gnt   = 1'b0;
    l_gnt   = 1'b0;
    state_d = state_q;
    case (state_q)
      ST_NORMAL: begin
        if (l_req) begin
          l_gnt   = 1'b1;
          state_d = ST_LOADER;
        end else if (f_req && (starve_q == STARVE_MAX)) begin
          f_gnt = 1'b1;
        end else if (d_req) begin
          d_gnt = 1'b1;
        end else if (f_req) begin
          f_gnt = 1'b1;
        end
      end
      ST_LOADER: begin
        l_gnt = l_req;
        if (!l_req) state_d = ST_RESUME;
      end
      ST_RESUME: state_d = ST_NORMAL;
      default:   state_d = ST_NORMAL;
    endcase
  end

  // RAM drive from the winner; address and write data hold when nobody is granted.
  always_comb begin
    ram_addr  = addr_q;
    ram_wdata = wdata_q;
    ram_we    = 1'b0;
    tag_d     = TAG_NONE;
    if (d_gnt) begin
      ram_addr  = d_addr;
      ram_wdata = d_wdata;
      ram_we    = d_we;
      tag_d     = d_we ? TAG_NONE : TAG_D;
    end else if (f_gnt) begin
      ram_addr = f_addr;
      tag_d    = TAG_F;
    end else if (l_gnt) begin
      ram_addr  = l_addr;
      ram_wdata = l_wdata;
      ram_we    = l_we;
      tag_d     = l_we ? TAG_NONE : TAG_L;
    end
    addr_d  = ram_addr;
    wdata_d = ram_wdata;
  end

  // Starve counter only moves while d/f are arbitrating; loader sessions freeze it.
  always_comb begin
    starve_d = starve_q;
    if (state_q == ST_NORMAL) begin
      if (f_req && !f_gnt)
        starve_d = (starve_q == STARVE_MAX) ? STARVE_MAX : starve_q + CNT_W'(1);
      else
        starve_d = '0;
    end
  end

  assign d_rvalid      = (tag_q == TAG_D);
  assign f_rvalid      = (tag_q == TAG_F);
  assign l_rvalid      = (tag_q == TAG_L);
  assign rdata         = ram_rdata;
  assign loader_active = (state_q != ST_NORMAL);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small synchronous RAM model attached to
// the RAM port; expected values are hand-derived from the arbitration rules.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [8:0]  d_addr;
  logic [15:0] d_wdata;
  logic        f_req, f_gnt, f_rvalid;
  logic [8:0]  f_addr;
  logic        l_req, l_we, l_gnt, l_rvalid;
  logic [8:0]  l_addr;
  logic [15:0] l_wdata;
  logic [15:0] rdata;
  logic [8:0]  ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_we;
  logic [15:0] ram_rdata;
  logic        loader_active;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [512];

  mem_port_arbiter #(.ADDR_W(9), .DATA_W(16), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid),
    .rdata(rdata), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_rdata(ram_rdata), .loader_active(loader_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge, then inputs for the new cycle are applied.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    d_req = 1'b0; d_we = 1'b0; f_req = 1'b0; l_req = 1'b0; l_we = 1'b0;
  endtask

  task automatic d_write(input logic [8:0] a, input logic [15:0] v);
    cyc();
    idle();
    d_req = 1'b1; d_we = 1'b1; d_addr = a; d_wdata = v;
    #1;
    chk("init_d_gnt", d_gnt, 1);
  endtask

  initial begin
    rst = 1'b0;
    idle();
    d_addr = '0; d_wdata = '0; f_addr = '0; l_addr = '0; l_wdata = '0;
    #2;
    chk("rst_gnts", {d_gnt, f_gnt, l_gnt}, 0);
    chk("rst_rvalids", {d_rvalid, f_rvalid, l_rvalid}, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_loader_active", loader_active, 0);
    cyc();
    rst = 1'b1;

    // Preload the words used by the read tests.
    d_write(9'h005, 16'hA5A5);
    d_write(9'h006, 16'h5A5A);
    d_write(9'h003, 16'h0333);

    // Reset lands while a data read is outstanding.
    cyc(); idle(); d_req = 1'b1; d_addr = 9'h006; #1;
    chk("mid_d_gnt", d_gnt, 1);
    cyc(); idle(); rst = 1'b0; #1;
    chk("mid_rst_d_rvalid", d_rvalid, 0);
    chk("mid_rst_ram_addr", ram_addr, 0);
    cyc(); rst = 1'b1; #1;
    chk("post_rst_d_rvalid", d_rvalid, 0);
    cyc(); #1;
    chk("post_rst_rvalids", {d_rvalid, f_rvalid, l_rvalid}, 0);
    chk("post_rst_gnts", {d_gnt, f_gnt, l_gnt}, 0);
    chk("post_rst_loader_active", loader_active, 0);

    // Data wins over fetch; write then read back.
    cyc(); idle();
    d_req = 1'b1; d_we = 1'b1; d_addr = 9'h010; d_wdata = 16'hBEEF;
    f_req = 1'b1; f_addr = 9'h020;
    #1;
    chk("dof_d_gnt", d_gnt, 1);
    chk("dof_f_gnt", f_gnt, 0);
    chk("dof_ram_we", ram_we, 1);
    chk("dof_ram_addr", ram_addr, 9'h010);
    chk("dof_ram_wdata", ram_wdata, 16'hBEEF);
    cyc(); d_we = 1'b0; #1;
    chk("dof_rd_d_gnt", d_gnt, 1);
    chk("dof_rd_ram_we", ram_we, 0);
    cyc(); idle(); #1;
    chk("dof_d_rvalid", d_rvalid, 1);
    chk("dof_rdata", rdata, 16'hBEEF);
    chk("hold_ram_addr", ram_addr, 9'h010);
    chk("hold_ram_we", ram_we, 0);

    // Starvation: D,D,D,D,F repeating with both ports requesting reads.
    for (int i = 0; i < 10; i++) begin
      cyc();
      d_req = 1'b1; d_we = 1'b0; d_addr = 9'h006;
      f_req = 1'b1; f_addr = 9'h005;
      #1;
      chk("stv_f_gnt", f_gnt, (i % 5 == 4) ? 1 : 0);
      chk("stv_d_gnt", d_gnt, (i % 5 == 4) ? 0 : 1);
      chk("stv_f_rvalid", f_rvalid, (i > 0 && (i - 1) % 5 == 4) ? 1 : 0);
      chk("stv_d_rvalid", d_rvalid, (i > 0 && (i - 1) % 5 != 4) ? 1 : 0);
      if (i > 0)
        chk("stv_rdata", rdata, ((i - 1) % 5 == 4) ? 16'hA5A5 : 16'h5A5A);
    end
    cyc(); idle(); #1;
    chk("stv_last_f_rvalid", f_rvalid, 1);
    chk("stv_last_rdata", rdata, 16'hA5A5);

    // Back-to-back reads from different ports return in order.
    cyc(); idle(); f_req = 1'b1; f_addr = 9'h005; #1;
    chk("rr_f_gnt", f_gnt, 1);
    cyc(); idle(); d_req = 1'b1; d_addr = 9'h006; #1;
    chk("rr_d_gnt", d_gnt, 1);
    chk("rr_rv1", {d_rvalid, f_rvalid, l_rvalid}, 3'b010);
    chk("rr_rdata1", rdata, 16'hA5A5);
    cyc(); idle(); #1;
    chk("rr_rv2", {d_rvalid, f_rvalid, l_rvalid}, 3'b100);
    chk("rr_rdata2", rdata, 16'h5A5A);

    // Loader session with d and f held; three writes then a final read.
    cyc();
    d_req = 1'b1; d_we = 1'b0; d_addr = 9'h006; f_req = 1'b1; f_addr = 9'h005;
    l_req = 1'b1; l_we = 1'b1; l_addr = 9'h000; l_wdata = 16'h1111;
    #1;
    chk("ld0_gnts", {d_gnt, f_gnt, l_gnt}, 3'b001);
    chk("ld0_ram_we", ram_we, 1);
    chk("ld0_ram_addr", ram_addr, 9'h000);
    chk("ld0_loader_active", loader_active, 0);
    cyc(); l_addr = 9'h001; l_wdata = 16'h2222; #1;
    chk("ld1_gnts", {d_gnt, f_gnt, l_gnt}, 3'b001);
    chk("ld1_ram_wdata", ram_wdata, 16'h2222);
    chk("ld1_loader_active", loader_active, 1);
    cyc(); l_addr = 9'h002; l_wdata = 16'h3333; #1;
    chk("ld2_gnts", {d_gnt, f_gnt, l_gnt}, 3'b001);
    chk("ld2_ram_addr", ram_addr, 9'h002);
    cyc(); l_we = 1'b0; l_addr = 9'h003; #1;
    chk("ld3_gnts", {d_gnt, f_gnt, l_gnt}, 3'b001);
    chk("ld3_ram_we", ram_we, 0);
    cyc(); l_req = 1'b0; #1;
    chk("ld4_gnts", {d_gnt, f_gnt, l_gnt}, 3'b000);
    chk("ld4_l_rvalid", l_rvalid, 1);
    chk("ld4_rdata", rdata, 16'h0333);
    chk("ld4_loader_active", loader_active, 1);
    cyc(); #1;
    chk("ld5_gnts", {d_gnt, f_gnt, l_gnt}, 3'b000);
    chk("ld5_l_rvalid", l_rvalid, 0);
    chk("ld5_loader_active", loader_active, 1);
    cyc(); #1;
    chk("ld6_d_gnt", d_gnt, 1);
    chk("ld6_loader_active", loader_active, 0);
    cyc(); f_req = 1'b0; d_addr = 9'h001; #1;
    chk("ld7_d_gnt", d_gnt, 1);
    chk("ld7_d_rvalid", d_rvalid, 1);
    chk("ld7_rdata", rdata, 16'h5A5A);
    cyc(); idle(); #1;
    chk("ld8_d_rvalid", d_rvalid, 1);
    chk("ld8_rdata", rdata, 16'h2222);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
